// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the control-signal pipeline: one stage register and its bubble value.
package ctrl_pipe_pkg;

    localparam int CTRL_BUNDLE_W = 10;
    localparam int DST_W         = 5;

    // Bundle widths are fixed here; the top-level CTRL_W/REG_ADDR_W must match them.
    typedef struct packed {
        logic                     valid;
        logic [CTRL_BUNDLE_W-1:0] ctrl;
        logic                     reg_write;
        logic                     is_load;
        logic [DST_W-1:0]         dst;
    } stage_t;

    function automatic stage_t bubble();
        return '0;
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_load_use_detect.sv
// Load-use hazard detector: a valid load in any checked stage whose non-zero destination
// matches a decode source register stalls decode.
module load_use_detect
    import ctrl_pipe_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic [DEPTH-1:0]       chk_valid,
    input  logic [DEPTH-1:0]       chk_is_load,
    input  logic [DEPTH-1:0]       chk_reg_write,
    input  logic [DEPTH*DST_W-1:0] chk_dst,
    input  logic                   dec_valid,
    input  logic [DST_W-1:0]       dec_src_a,
    input  logic [DST_W-1:0]       dec_src_b,
    output logic                   load_use_stall
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (chk_valid[k] && chk_is_load[k] && chk_reg_write[k] &&
                (chk_dst[k*DST_W +: DST_W] != '0) &&
                ((chk_dst[k*DST_W +: DST_W] == dec_src_a) ||
                 (chk_dst[k*DST_W +: DST_W] == dec_src_b))) begin
                hit = 1'b1;
            end
        end
        load_use_stall = dec_valid & hit;
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline from decode through NUM_STAGES registers with per-stage flush,
// global freeze, load-use stall and in-flight/retire counters.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int CTRL_W         = CTRL_BUNDLE_W,
    parameter int REG_ADDR_W     = DST_W,
    parameter int LOAD_USE_DEPTH = 1,
    parameter int RETIRE_W       = 32,
    localparam int CNT_W         = $clog2(NUM_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             dec_valid,
    input  logic [CTRL_W-1:0]                dec_ctrl,
    input  logic                             dec_reg_write,
    input  logic                             dec_is_load,
    input  logic [REG_ADDR_W-1:0]            dec_dst,
    input  logic [REG_ADDR_W-1:0]            dec_src_a,
    input  logic [REG_ADDR_W-1:0]            dec_src_b,
    input  logic                             ext_stall,
    input  logic [NUM_STAGES-1:0]            flush_vec,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [NUM_STAGES*CTRL_W-1:0]     stage_ctrl,
    output logic [NUM_STAGES-1:0]            stage_reg_write,
    output logic [NUM_STAGES*REG_ADDR_W-1:0] stage_dst,
    output logic                             load_use_stall,
    output logic                             stall_decode,
    output logic [CNT_W-1:0]                 in_flight,
    output logic [RETIRE_W-1:0]              retire_count
);

    stage_t                      stage_q [NUM_STAGES];
    stage_t                      stage_d [NUM_STAGES];
    logic [NUM_STAGES-1:0]       next_valid;
    logic [LOAD_USE_DEPTH-1:0]       chk_valid;
    logic [LOAD_USE_DEPTH-1:0]       chk_is_load;
    logic [LOAD_USE_DEPTH-1:0]       chk_reg_write;
    logic [LOAD_USE_DEPTH*DST_W-1:0] chk_dst;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_STAGES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_STAGES; k++) c = c + CNT_W'(v[k]);
        return c;
    endfunction

    for (genvar k = 0; k < LOAD_USE_DEPTH; k++) begin : g_chk
        assign chk_valid[k]                = stage_q[k].valid;
        assign chk_is_load[k]              = stage_q[k].is_load;
        assign chk_reg_write[k]            = stage_q[k].reg_write;
        assign chk_dst[k*DST_W +: DST_W]   = stage_q[k].dst;
    end

    load_use_detect #(
        .DEPTH(LOAD_USE_DEPTH)
    ) u_load_use_detect (
        .chk_valid     (chk_valid),
        .chk_is_load   (chk_is_load),
        .chk_reg_write (chk_reg_write),
        .chk_dst       (chk_dst),
        .dec_valid     (dec_valid),
        .dec_src_a     (dec_src_a),
        .dec_src_b     (dec_src_b),
        .load_use_stall(load_use_stall)
    );

    assign stall_decode = load_use_stall | ext_stall;

    // Freeze dominates; then flush; then the load-use bubble into stage 0; then normal flow.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) stage_d[k] = stage_q[k];
        if (!ext_stall) begin
            if (flush_vec[0] || load_use_stall || !dec_valid) begin
                stage_d[0] = bubble();
            end else begin
                stage_d[0] = '{valid: 1'b1, ctrl: dec_ctrl, reg_write: dec_reg_write,
                               is_load: dec_is_load, dst: dec_dst};
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_d[k] = flush_vec[k] ? bubble() : stage_q[k-1];
            end
        end
        for (int k = 0; k < NUM_STAGES; k++) next_valid[k] = stage_d[k].valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= bubble();
            in_flight    <= '0;
            retire_count <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= stage_d[k];
            in_flight <= popcount(next_valid);
            if (!ext_stall && stage_q[NUM_STAGES-1].valid) begin
                retire_count <= retire_count + RETIRE_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
        assign stage_valid[k]                          = stage_q[k].valid;
        assign stage_ctrl[k*CTRL_W +: CTRL_W]          = stage_q[k].ctrl;
        assign stage_reg_write[k]                      = stage_q[k].valid & stage_q[k].reg_write;
        assign stage_dst[k*REG_ADDR_W +: REG_ADDR_W]   = stage_q[k].dst;
    end

endmodule
